apb_cmd_master: RTL and testbench

Single-outstanding APB master that sits directly upstream of the 3-to-8 register decoder slave. It converts a valid/ready command interface into APB SETUP/ACCESS phases, waits on pready, and returns pslverr and prdata on a valid/ready response channel. It is the test and control front-end that drives the decoder's register bank.

---
 rtl/apb_cmd_master.sv | 91 +++++++++
 tb/tb_apb_cmd_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB master turning a valid/ready command into SETUP/ACCESS phases.
// Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts after TIMEOUT_CYC cycles.
module apb_cmd_master #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic              pslverr,
   input  logic [DATA_W-1:0] prdata
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t r_state, w_next;
   logic w_accept, w_done, w_abort;
   assign cmd_ready = (r_state == IDLE) && (!rsp_valid || rsp_ready);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_done    = (r_state == ACCESS) && pready;
`ifdef APB_TIMEOUT_EN
   logic [7:0] r_wdog;
   // pready in the last allowed cycle still completes normally
   assign w_abort = (r_state == ACCESS) && !pready && (r_wdog == 8'(TIMEOUT_CYC - 1));
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         r_wdog <= 8'd0;
      else if (r_state == SETUP)
         r_wdog <= 8'd0;
      else if (r_state == ACCESS && !pready)
         r_wdog <= r_wdog + 8'd1;
   end
`else
   assign w_abort = 1'b0;
`endif
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end
   always_comb begin
      w_next = r_state == IDLE  ? (w_accept ? SETUP : IDLE) :
               r_state == SETUP ? ACCESS :
               (w_done || w_abort) ? IDLE : ACCESS;
   end
   // decoded from the async-reset state so a reset drops the bus without a clock
   always_comb begin
      psel    = r_state != IDLE;
      penable = r_state == ACCESS;
   end
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         if (w_accept) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
         end
         if (w_done || w_abort) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= w_done ? pslverr : 1'b1;
            rsp_timeout <= !w_done;
            rsp_rdata   <= (w_done && !pwrite) ? prdata : '0;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized scoreboard bench for apb_cmd_master with an APB slave model.
// Honours APB_TIMEOUT_EN the same way as the design.
module tb_apb_cmd_master;
   localparam int TO = 16;
   logic pclk = 0, preset = 1, cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
   logic pready = 0, pslverr = 0;
   logic [7:0] cmd_addr = 0, cmd_wdata = 0, prdata = 0;
   logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
   logic [7:0] rsp_rdata, paddr, pwdata;
   typedef struct { logic [7:0] addr; logic wr; logic [7:0] wdata; int acc; } apb_t;
   typedef struct { int wt; logic err; logic [7:0] rd; } sl_t;
   typedef struct { logic err; logic to; logic [7:0] rd; } rsp_t;
   apb_t exp_apb[$];
   sl_t  slq[$];
   rsp_t exp_rsp[$];
   int n_chk = 0, n_fail = 0, rr_mode = 1;

   apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
      .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
      .pslverr(pslverr), .prdata(prdata));

   initial forever #5 pclk = ~pclk;
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   initial forever begin
      @(posedge pclk); #1;
      rsp_ready = rr_mode == 1 ? 1'b1 : rr_mode == 2 ? 1'b0 : 1'($urandom);
   end

   // slave: inserts wt wait states, drives noise on pready/pslverr/prdata outside ACCESS
   initial begin
      int k;
      sl_t cur;
      k = 0;
      cur = '{0, 1'b0, 8'h00};
      forever begin
         @(posedge pclk); #1;
         if (psel && penable) begin
            if (k == 0 && slq.size() > 0) cur = slq.pop_front();
            pready  = (k == cur.wt);
            pslverr = pready ? cur.err : 1'($urandom);
            prdata  = pready ? cur.rd : 8'($urandom);
            k++;
         end else begin
            k = 0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = 8'($urandom);
         end
      end
   end

   initial begin
      apb_t cur;
      int acc;
      bit have, prev_setup;
      acc = 0; have = 0; prev_setup = 0;
      cur = '{8'h00, 1'b0, 8'h00, 0};
      forever begin
         @(negedge pclk);
         if (preset) begin
            exp_apb.delete(); slq.delete(); exp_rsp.delete();
            have = 0; acc = 0; prev_setup = 0;
         end else begin
            if (rsp_valid) begin
               if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  chk("rsp_err", rsp_err, exp_rsp[0].err);
                  chk("rsp_timeout", rsp_timeout, exp_rsp[0].to);
                  chk("rsp_rdata", rsp_rdata, exp_rsp[0].rd);
                  if (rsp_ready) void'(exp_rsp.pop_front());
               end
            end
            if (prev_setup) chk("setup_to_access", psel && penable, 1);
            if (psel && !penable) begin
               if (exp_apb.size() == 0) chk("apb_unexpected", 1, 0);
               else begin
                  cur = exp_apb.pop_front();
                  chk("setup_paddr", paddr, cur.addr);
                  chk("setup_pwrite", pwrite, cur.wr);
                  chk("setup_pwdata", pwdata, cur.wdata);
                  have = 1; acc = 0;
               end
            end else if (psel && penable) begin
               acc++;
               if (!have) chk("access_without_setup", 1, 0);
               else begin
                  chk("paddr_hold", paddr, cur.addr);
                  chk("pwrite_hold", pwrite, cur.wr);
                  chk("pwdata_hold", pwdata, cur.wdata);
               end
            end else begin
               chk("penable_idle", penable, 0);
               if (have) begin
                  chk("access_cycles", acc, cur.acc);
                  chk("paddr_retain", paddr, cur.addr);
                  have = 0;
               end
            end
            prev_setup = psel && !penable;
         end
      end
   end

   task automatic push_exp(bit w, logic [7:0] a, logic [7:0] d, int wt, bit e, logic [7:0] rd);
      bit to;
      to = 0;
`ifdef APB_TIMEOUT_EN
      to = wt >= TO;
`endif
      exp_apb.push_back('{a, w, w ? d : 8'h00, to ? TO : wt + 1});
      slq.push_back('{wt, e, rd});
      exp_rsp.push_back('{to ? 1'b1 : e, to, (to || w) ? 8'h00 : rd});
   endtask

   task automatic do_cmd(bit w, logic [7:0] a, logic [7:0] d, int wt, bit e, logic [7:0] rd);
      bit acc;
      @(posedge pclk); #1;
      push_exp(w, a, d, wt, e, rd);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      acc = 0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge pclk);
         acc = cmd_ready;
         @(posedge pclk); #1;
      end
      if (!acc) chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
   endtask

   task automatic drain(int budget);
      for (int i = 0; i < budget && (exp_rsp.size() != 0 || psel || rsp_valid); i++) @(negedge pclk);
      chk("drain_pending", exp_rsp.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0); chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_cmd_ready", cmd_ready, 1);
      @(posedge pclk); #1;
      preset = 0;
      do_cmd(1, 8'h03, 8'hA5, 0, 0, 8'h00);
      @(negedge pclk);
      chk("t1_setup_psel", psel, 1); chk("t1_setup_penable", penable, 0);
      chk("t1_paddr", paddr, 8'h03); chk("t1_pwdata", pwdata, 8'hA5); chk("t1_pwrite", pwrite, 1);
      @(negedge pclk);
      chk("t1_access_psel", psel, 1); chk("t1_access_penable", penable, 1);
      @(negedge pclk);
      chk("t1_rsp_valid_n3", rsp_valid, 1); chk("t1_psel_done", psel, 0);
      drain(50);
      do_cmd(1, 8'h09, 8'h5A, 0, 1, 8'h00);
      drain(50);
      do_cmd(0, 8'h05, 8'hFF, 3, 0, 8'h3C);
      drain(50);
      rr_mode = 2;
      do_cmd(1, 8'h00, 8'h11, 0, 0, 8'h00);
      push_exp(1, 8'h07, 8'h77, 0, 0, 8'h00);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h07; cmd_wdata = 8'h77;
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge pclk);
      chk("stall_rsp_valid", rsp_valid, 1);
      repeat (5) begin
         @(negedge pclk);
         chk("stall_cmd_ready", cmd_ready, 0); chk("stall_psel", psel, 0);
      end
      rr_mode = 1;
      @(negedge pclk);
      chk("release_cmd_ready", cmd_ready, 1); chk("release_psel", psel, 0);
      @(posedge pclk); #1;
      cmd_valid = 0;
      @(negedge pclk);
      chk("b2b_setup_psel", psel, 1); chk("b2b_setup_penable", penable, 0);
      drain(50);
      do_cmd(1, 8'h0A, 8'h5A, 30, 0, 8'h00);
      @(posedge pclk); #3;
      preset = 1;
      #1;
      chk("async_rst_psel", psel, 0); chk("async_rst_penable", penable, 0);
      @(posedge pclk); #1;
      preset = 0;
      repeat (2) @(negedge pclk);
      chk("post_rst_rsp_valid", rsp_valid, 0); chk("post_rst_cmd_ready", cmd_ready, 1);
      do_cmd(0, 8'h06, 8'h00, 1, 0, 8'hC3);
      drain(50);
      rr_mode = 0;
      for (int n = 0; n < 40; n++) begin
         do_cmd(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4), 1'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge pclk);
      end
      drain(500);
      rr_mode = 1;
`ifdef APB_TIMEOUT_EN
      do_cmd(1, 8'h10, 8'h22, TO, 0, 8'h00);
      drain(100);
      do_cmd(0, 8'h11, 8'h00, TO - 1, 0, 8'h99);
      drain(100);
      do_cmd(0, 8'h12, 8'h00, 100, 1, 8'h55);
      drain(100);
`else
      do_cmd(0, 8'h13, 8'h00, 200, 0, 8'h66);
      repeat (100) @(negedge pclk);
      chk("no_watchdog_psel", psel, 1);
      drain(400);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
